// File: rtl/running_min_max_16_bit.sv
// Windowed running minimum/maximum tracker for an unsigned 16-bit sample stream.
// Publishes per-window extremes and their first positions, then restarts.
module running_min_max_16_bit #(
  parameter int unsigned WINDOW_LENGTH = 8
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Clear_In,
  input  logic [15:0] Data_In,
  input  logic        Data_Valid_In,
  output logic        Ready_Out,
  output logic [15:0] Min_Out,
  output logic [15:0] Max_Out,
  output logic [15:0] Min_Index_Out,
  output logic [15:0] Max_Index_Out,
  output logic        Window_Done_Out
);

  localparam int unsigned CNT_W = (WINDOW_LENGTH > 2) ? $clog2(WINDOW_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WINDOW_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [15:0]        run_min_q, run_min_n;
  logic [15:0]        run_max_q, run_max_n;
  logic [CNT_W-1:0]   min_idx_q, min_idx_n;
  logic [CNT_W-1:0]   max_idx_q, max_idx_n;
  logic               load_result;
  logic               accept;

  // Ready_Out is a registered copy of (state != DONE), so it doubles as the accept gate.
  assign accept = Data_Valid_In & Ready_Out;

  always_comb begin
    state_n     = state_q;
    count_n     = count_q;
    run_min_n   = run_min_q;
    run_max_n   = run_max_q;
    min_idx_n   = min_idx_q;
    max_idx_n   = max_idx_q;
    load_result = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          run_min_n = Data_In;
          run_max_n = Data_In;
          min_idx_n = '0;
          max_idx_n = '0;
          count_n   = CNT_W'(1);
          state_n   = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (Data_In < run_min_q) begin
            run_min_n = Data_In;
            min_idx_n = count_q;
          end
          if (Data_In > run_max_q) begin
            run_max_n = Data_In;
            max_idx_n = count_q;
          end
          if (count_q == LAST_COUNT) begin
            count_n     = '0;
            load_result = 1'b1;
            state_n     = DONE;
          end else begin
            count_n = count_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort overrides any same-cycle accept; a pulse already registered still completes.
    if (Clear_In) begin
      state_n     = IDLE;
      count_n     = '0;
      run_min_n   = '0;
      run_max_n   = '0;
      min_idx_n   = '0;
      max_idx_n   = '0;
      load_result = 1'b0;
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q         <= IDLE;
      count_q         <= '0;
      run_min_q       <= '0;
      run_max_q       <= '0;
      min_idx_q       <= '0;
      max_idx_q       <= '0;
      Ready_Out       <= 1'b1;
      Window_Done_Out <= 1'b0;
      Min_Out         <= '0;
      Max_Out         <= '0;
      Min_Index_Out   <= '0;
      Max_Index_Out   <= '0;
    end else begin
      state_q         <= state_n;
      count_q         <= count_n;
      run_min_q       <= run_min_n;
      run_max_q       <= run_max_n;
      min_idx_q       <= min_idx_n;
      max_idx_q       <= max_idx_n;
      Ready_Out       <= (state_n != DONE);
      Window_Done_Out <= (state_n == DONE);
      if (load_result) begin
        Min_Out       <= run_min_n;
        Max_Out       <= run_max_n;
        Min_Index_Out <= 16'(min_idx_n);
        Max_Index_Out <= 16'(max_idx_n);
      end
    end
  end

endmodule
